trigger_sequencer: RTL and testbench
====================================

Name: trigger_sequencer

Overview:
- Parametrised, multi-channel trigger scheduler for the power-supply trigger path.
- Detects a rising edge on the trigger input, aligns it to a free-running frame counter (serial frame timing, default 10 bit-slots), optionally delays it by a programmable number of frames, then drives a per-channel trigger strobe for a programmable number of frames.
- Adds channel masking, retrigger/extend mode, enable/abort, and a missed-trigger counter.

Parameters:
- FRAME_LEN, 10, cycles per frame; frame_counter wraps at FRAME_LEN-1; legal values are ≥2.
- CNT_W, 4, frame_counter width; must satisfy 2^CNT_W ≥ FRAME_LEN.
- NUM_CH, 4, number of trigger output channels.
- DELAY_W, 8, width of delay_frames.
- HOLD_W, 4, width of hold_frames.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  1 = accept triggers; 0 = ignore triggers and abort a sequence in progress.
- trigger_in  in  1  trigger request, synchronous to clk; only its rising edge is used.
- ch_mask  in  NUM_CH  channels to fire; latched on an accepted trigger.
- delay_frames  in  DELAY_W  whole frames to wait after frame alignment; latched on an accepted trigger.
- hold_frames  in  HOLD_W  active length minus 1, in frames; latched on an accepted trigger.
- retrig_mode  in  1  1 = a rising edge during ACTIVE extends the hold.
- clear_missed  in  1  synchronous clear of missed_count.
- is_trigger  out  NUM_CH  per-channel trigger strobe.
- frame_counter  out  CNT_W  free-running frame position.
- frame_tick  out  1  high when frame_counter == FRAME_LEN-1.
- busy  out  1  high when state ≠ IDLE.
- missed_count  out  8  count of dropped trigger edges; saturates.

Behaviour:
- Reset values: state=IDLE, frame_counter=0, trig_d=0, mask_q/dcnt/hcnt=0, missed_count=0.
  - Therefore is_trigger=0, busy=0, frame_tick=0.
  - Reset asserted mid-sequence returns to these values immediately.
- Frame counter:
  - Increments every cycle and wraps FRAME_LEN-1 → 0.
  - Unaffected by enable or by state.
  - frame_tick is decoded combinationally from frame_counter.
- Edge detect:
  - trig_d is trigger_in registered each cycle.
  - rise = trigger_in & ~trig_d.
  - A level held high produces exactly one rise.
- States: IDLE, WAIT, ACTIVE.
  - Outputs decode from registered state only: is_trigger = (state==ACTIVE) ? mask_q : 0.
  - There is no combinational path from inputs to is_trigger or busy.
- IDLE:
  - If enable & rise: latch mask_q←ch_mask, dcnt←delay_frames, hold_q←hold_frames; next state WAIT.
  - A frame_tick in the same cycle is not counted, so a full frame boundary is always awaited.
- WAIT, on frame_tick:
  - If dcnt==0: go to ACTIVE and load hcnt←hold_q.
  - Otherwise dcnt decrements.
  - Delay D therefore means D+1 frame ticks before ACTIVE.
- ACTIVE, on frame_tick:
  - If hcnt==0: go to IDLE.
  - Otherwise hcnt decrements.
  - is_trigger is high for exactly (hold_frames+1)×FRAME_LEN cycles, starting at frame_counter=0.
- Retrigger with retrig_mode=1 in ACTIVE:
  - rise reloads hcnt←hold_q and state stays ACTIVE.
  - mask_q is not re-latched.
  - Retrigger has priority over a same-cycle exit (frame_tick with hcnt==0).
- Missed triggers:
  - rise while enable=1 and in WAIT, or in ACTIVE with retrig_mode=0, increments missed_count.
  - missed_count saturates at 255.
  - rise with enable=0 is not counted.
  - clear_missed has priority over a simultaneous increment (result is 0).
- Enable/abort:
  - enable=0 in WAIT or ACTIVE forces IDLE on the next edge.
  - is_trigger drops that edge; the latched values are discarded.
- ch_mask=0 accepted: the sequence runs with busy high and is_trigger all-zero.

Test Plan:
- Defaults, delay=0, hold=0, mask=4'b0101; trigger_in rises with frame_counter=3 → busy=1 from counter 4; is_trigger=4'b0101 for 10 cycles (counter 0..9); IDLE at the next counter 0.
- delay=2, hold=1, mask=4'b1111; trigger at counter 7 → is_trigger=4'hF starts after the 3rd frame_tick and lasts 20 cycles; busy falls with it.
- trigger rise in the same cycle as frame_tick (counter 9) from IDLE → WAIT persists 10 cycles; ACTIVE starts at the following counter-0 boundary.
- retrig_mode=0, second rise during WAIT and another during ACTIVE → missed_count=2, timing unchanged. Repeat with retrig_mode=1 and hold=0, rise in ACTIVE at counter 5 → is_trigger extends one further full frame; missed_count unchanged.
- 300 rises during a long delay (delay=255) → missed_count saturates at 255. Then clear_missed coincident with a rise → missed_count=0.
- enable low for one cycle mid-ACTIVE → is_trigger=0 and busy=0 the next cycle. Async reset mid-WAIT → all outputs 0 immediately; frame_counter restarts at 0.

Source files
------------

// File: rtl/trigger_sequencer.sv
// trigger_sequencer: frame-aligned, multi-channel trigger scheduler.
// A rising edge on trigger_in is aligned to the next frame boundary, optionally
// delayed by whole frames, then drives the masked channel strobes for a
// programmable number of whole frames. Dropped edges are counted.
module trigger_sequencer #(
    parameter int FRAME_LEN = 10,
    parameter int CNT_W     = 4,
    parameter int NUM_CH    = 4,
    parameter int DELAY_W   = 8,
    parameter int HOLD_W    = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               trigger_in,
    input  logic [NUM_CH-1:0]  ch_mask,
    input  logic [DELAY_W-1:0] delay_frames,
    input  logic [HOLD_W-1:0]  hold_frames,
    input  logic               retrig_mode,
    input  logic               clear_missed,
    output logic [NUM_CH-1:0]  is_trigger,
    output logic [CNT_W-1:0]   frame_counter,
    output logic               frame_tick,
    output logic               busy,
    output logic [7:0]         missed_count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(FRAME_LEN - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               trig_prev_q;
    logic [NUM_CH-1:0]  mask_q, mask_d;
    logic [DELAY_W-1:0] dcnt_q, dcnt_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [HOLD_W-1:0]  hcnt_q, hcnt_d;
    // Set by a mid-frame retrigger: the frame boundary that closes the
    // partially elapsed frame is not counted against the reloaded hold.
    logic               pend_q, pend_d;
    logic [7:0]         missed_q, missed_d;

    logic               rise_s;
    logic               tick_s;
    logic               miss_s;

    assign tick_s = (cnt_q == LAST_SLOT);
    assign rise_s = trigger_in & ~trig_prev_q;
    assign miss_s = enable & rise_s &
                    ((state_q == ST_WAIT) | ((state_q == ST_ACTIVE) & ~retrig_mode));

    // Free-running frame position, wrapping at the last slot.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (tick_s) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Sequencer next state: accept, frame-aligned delay, active hold, retrigger, abort.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        dcnt_d  = dcnt_q;
        hold_d  = hold_q;
        hcnt_d  = hcnt_q;
        pend_d  = pend_q;
        case (state_q)
            ST_IDLE: begin
                if (enable && rise_s) begin
                    mask_d  = ch_mask;
                    dcnt_d  = delay_frames;
                    hold_d  = hold_frames;
                    hcnt_d  = '0;
                    pend_d  = 1'b0;
                    state_d = ST_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!enable) begin
                    mask_d  = '0;
                    dcnt_d  = '0;
                    hold_d  = '0;
                    hcnt_d  = '0;
                    pend_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (tick_s) begin
                    if (dcnt_q == '0) begin
                        hcnt_d  = hold_q;
                        pend_d  = 1'b0;
                        state_d = ST_ACTIVE;
                    end else begin
                        dcnt_d = dcnt_q - DELAY_W'(1);
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_ACTIVE: begin
                if (!enable) begin
                    mask_d  = '0;
                    dcnt_d  = '0;
                    hold_d  = '0;
                    hcnt_d  = '0;
                    pend_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (retrig_mode && rise_s) begin
                    // Reload wins over a same-cycle exit; a retrigger landing
                    // on the boundary itself needs no skipped tick.
                    hcnt_d = hold_q;
                    pend_d = ~tick_s;
                end else if (tick_s) begin
                    if (pend_q) begin
                        pend_d = 1'b0;
                    end else if (hcnt_q == '0) begin
                        mask_d  = '0;
                        dcnt_d  = '0;
                        hold_d  = '0;
                        state_d = ST_IDLE;
                    end else begin
                        hcnt_d = hcnt_q - HOLD_W'(1);
                    end
                end else begin
                    state_d = ST_ACTIVE;
                end
            end
            default: begin
                mask_d  = '0;
                dcnt_d  = '0;
                hold_d  = '0;
                hcnt_d  = '0;
                pend_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Missed-edge counter: clear has priority, increment saturates at 255.
    always_comb begin
        missed_d = missed_q;
        if (clear_missed) begin
            missed_d = 8'd0;
        end else if (miss_s && (missed_q != 8'd255)) begin
            missed_d = missed_q + 8'd1;
        end else begin
            missed_d = missed_q;
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            trig_prev_q <= 1'b0;
            mask_q      <= '0;
            dcnt_q      <= '0;
            hold_q      <= '0;
            hcnt_q      <= '0;
            pend_q      <= 1'b0;
            missed_q    <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            trig_prev_q <= trigger_in;
            mask_q      <= mask_d;
            dcnt_q      <= dcnt_d;
            hold_q      <= hold_d;
            hcnt_q      <= hcnt_d;
            pend_q      <= pend_d;
            missed_q    <= missed_d;
        end
    end

    // Outputs decode from registered state only.
    assign is_trigger    = (state_q == ST_ACTIVE) ? mask_q : '0;
    assign busy          = (state_q != ST_IDLE);
    assign frame_counter = cnt_q;
    assign frame_tick    = tick_s;
    assign missed_count  = missed_q;

endmodule

// File: tb/tb_trigger_sequencer.sv
// Directed self-checking bench for trigger_sequencer (default parameters).
module tb_trigger_sequencer;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       trigger_in;
    logic [3:0] ch_mask;
    logic [7:0] delay_frames;
    logic [3:0] hold_frames;
    logic       retrig_mode;
    logic       clear_missed;
    logic [3:0] is_trigger;
    logic [3:0] frame_counter;
    logic       frame_tick;
    logic       busy;
    logic [7:0] missed_count;

    int errors = 0;
    int checks = 0;

    trigger_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .trigger_in   (trigger_in),
        .ch_mask      (ch_mask),
        .delay_frames (delay_frames),
        .hold_frames  (hold_frames),
        .retrig_mode  (retrig_mode),
        .clear_missed (clear_missed),
        .is_trigger   (is_trigger),
        .frame_counter(frame_counter),
        .frame_tick   (frame_tick),
        .busy         (busy),
        .missed_count (missed_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Advance to the negedge where frame_counter equals v (bounded).
    task automatic wait_fc(input logic [3:0] v);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (frame_counter == v) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL wait_fc got=%0d exp=%0d", frame_counter, v);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (is_trigger !== 4'b0000) begin errors++; $display("FAIL reset is_trigger got=%b exp=0000", is_trigger); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy got=%b exp=0", busy); end
        checks++; if (frame_counter !== 4'd0) begin errors++; $display("FAIL reset frame_counter got=%0d exp=0", frame_counter); end
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset frame_tick got=%b exp=0", frame_tick); end
        checks++; if (missed_count !== 8'd0) begin errors++; $display("FAIL reset missed got=%0d exp=0", missed_count); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (frame_counter !== 4'd1) begin errors++; $display("FAIL reset first_count got=%0d exp=1", frame_counter); end
    endtask

    // delay=0 hold=0, trigger at counter 3; level held high yields one rise.
    task automatic test_basic();
        logic [3:0] exp_t;
        logic       exp_b;
        logic [3:0] exp_fc;
        enable = 1'b1; retrig_mode = 1'b0; ch_mask = 4'b0101;
        delay_frames = 8'd0; hold_frames = 4'd0;
        wait_fc(4'd3);
        trigger_in = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            exp_fc = 4'((3 + k) % 10);
            exp_b  = (k <= 16);
            exp_t  = (k >= 7 && k <= 16) ? 4'b0101 : 4'b0000;
            checks++; if (frame_counter !== exp_fc) begin errors++; $display("FAIL basic frame_counter k=%0d got=%0d exp=%0d", k, frame_counter, exp_fc); end
            checks++; if (frame_tick !== (exp_fc == 4'd9)) begin errors++; $display("FAIL basic frame_tick k=%0d got=%b", k, frame_tick); end
            checks++; if (busy !== exp_b) begin errors++; $display("FAIL basic busy k=%0d got=%b exp=%b", k, busy, exp_b); end
            checks++; if (is_trigger !== exp_t) begin errors++; $display("FAIL basic is_trigger k=%0d got=%b exp=%b", k, is_trigger, exp_t); end
            if (k == 5) trigger_in = 1'b0;
        end
        checks++; if (missed_count !== 8'd0) begin errors++; $display("FAIL basic missed got=%0d exp=0", missed_count); end
    endtask

    // delay=2 hold=1, trigger at counter 7: active after 3rd tick for 20 cycles.
    task automatic test_delay();
        logic [3:0] exp_t;
        logic       exp_b;
        ch_mask = 4'b1111; delay_frames = 8'd2; hold_frames = 4'd1;
        wait_fc(4'd7);
        trigger_in = 1'b1;
        for (int k = 1; k <= 44; k++) begin
            @(negedge clk);
            trigger_in = 1'b0;
            exp_b = (k <= 42);
            exp_t = (k >= 23 && k <= 42) ? 4'b1111 : 4'b0000;
            checks++; if (busy !== exp_b) begin errors++; $display("FAIL delay busy k=%0d got=%b exp=%b", k, busy, exp_b); end
            checks++; if (is_trigger !== exp_t) begin errors++; $display("FAIL delay is_trigger k=%0d got=%b exp=%b", k, is_trigger, exp_t); end
        end
    endtask

    // Rise coincident with frame_tick: a full frame of WAIT follows.
    task automatic test_tick_align();
        logic [3:0] exp_t;
        logic       exp_b;
        ch_mask = 4'b0010; delay_frames = 8'd0; hold_frames = 4'd0;
        wait_fc(4'd9);
        trigger_in = 1'b1;
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            trigger_in = 1'b0;
            exp_b = (k <= 20);
            exp_t = (k >= 11 && k <= 20) ? 4'b0010 : 4'b0000;
            checks++; if (busy !== exp_b) begin errors++; $display("FAIL align busy k=%0d got=%b exp=%b", k, busy, exp_b); end
            checks++; if (is_trigger !== exp_t) begin errors++; $display("FAIL align is_trigger k=%0d got=%b exp=%b", k, is_trigger, exp_t); end
        end
    endtask

    // Missed edges with retrig_mode=0, then extension with retrig_mode=1.
    task automatic test_missed_retrig();
        logic [3:0] exp_t;
        logic       exp_b;
        @(negedge clk); clear_missed = 1'b1;
        @(negedge clk); clear_missed = 1'b0;
        checks++; if (missed_count !== 8'd0) begin errors++; $display("FAIL clear missed got=%0d exp=0", missed_count); end
        ch_mask = 4'b0101; delay_frames = 8'd0; hold_frames = 4'd0; retrig_mode = 1'b0;
        wait_fc(4'd3);
        trigger_in = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            exp_b = (k <= 16);
            exp_t = (k >= 7 && k <= 16) ? 4'b0101 : 4'b0000;
            checks++; if (busy !== exp_b) begin errors++; $display("FAIL missed busy k=%0d got=%b exp=%b", k, busy, exp_b); end
            checks++; if (is_trigger !== exp_t) begin errors++; $display("FAIL missed is_trigger k=%0d got=%b exp=%b", k, is_trigger, exp_t); end
            trigger_in = (k == 3 || k == 9);
        end
        checks++; if (missed_count !== 8'd2) begin errors++; $display("FAIL missed count got=%0d exp=2", missed_count); end

        retrig_mode = 1'b1;
        wait_fc(4'd3);
        trigger_in = 1'b1;
        for (int k = 1; k <= 28; k++) begin
            @(negedge clk);
            exp_b = (k <= 26);
            exp_t = (k >= 7 && k <= 26) ? 4'b0101 : 4'b0000;
            checks++; if (busy !== exp_b) begin errors++; $display("FAIL retrig busy k=%0d got=%b exp=%b", k, busy, exp_b); end
            checks++; if (is_trigger !== exp_t) begin errors++; $display("FAIL retrig is_trigger k=%0d got=%b exp=%b", k, is_trigger, exp_t); end
            trigger_in = (k == 12);
        end
        checks++; if (missed_count !== 8'd2) begin errors++; $display("FAIL retrig missed got=%0d exp=2", missed_count); end
        retrig_mode = 1'b0;
    endtask

    // 300 rises during delay=255 saturate the counter; clear beats a coincident rise.
    task automatic test_saturate();
        ch_mask = 4'b1111; delay_frames = 8'd255; hold_frames = 4'd0;
        wait_fc(4'd0);
        trigger_in = 1'b1;
        @(negedge clk); trigger_in = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk); trigger_in = 1'b1;
            @(negedge clk); trigger_in = 1'b0;
        end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sat busy got=%b exp=1", busy); end
        checks++; if (is_trigger !== 4'b0000) begin errors++; $display("FAIL sat is_trigger got=%b exp=0000", is_trigger); end
        checks++; if (missed_count !== 8'd255) begin errors++; $display("FAIL sat missed got=%0d exp=255", missed_count); end
        trigger_in = 1'b1; clear_missed = 1'b1;
        @(negedge clk);
        trigger_in = 1'b0; clear_missed = 1'b0;
        checks++; if (missed_count !== 8'd0) begin errors++; $display("FAIL sat clear got=%0d exp=0", missed_count); end
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sat abort busy got=%b exp=0", busy); end
    endtask

    // enable low for one cycle mid-ACTIVE aborts; a rise while disabled is not counted.
    task automatic test_enable_abort();
        ch_mask = 4'b0101; delay_frames = 8'd0; hold_frames = 4'd0;
        wait_fc(4'd3);
        trigger_in = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            trigger_in = 1'b0;
        end
        checks++; if (is_trigger !== 4'b0101) begin errors++; $display("FAIL abort pre is_trigger got=%b exp=0101", is_trigger); end
        enable = 1'b0; trigger_in = 1'b1;
        @(negedge clk);
        checks++; if (is_trigger !== 4'b0000) begin errors++; $display("FAIL abort is_trigger got=%b exp=0000", is_trigger); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort busy got=%b exp=0", busy); end
        checks++; if (missed_count !== 8'd0) begin errors++; $display("FAIL abort missed got=%0d exp=0", missed_count); end
        enable = 1'b1; trigger_in = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort restart busy got=%b exp=0", busy); end
    endtask

    // ch_mask=0 is accepted: busy follows the sequence, strobes stay low.
    task automatic test_zero_mask();
        logic exp_b;
        ch_mask = 4'b0000; delay_frames = 8'd0; hold_frames = 4'd0;
        wait_fc(4'd5);
        trigger_in = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            trigger_in = 1'b0;
            exp_b = (k <= 14);
            checks++; if (busy !== exp_b) begin errors++; $display("FAIL zmask busy k=%0d got=%b exp=%b", k, busy, exp_b); end
            checks++; if (is_trigger !== 4'b0000) begin errors++; $display("FAIL zmask is_trigger k=%0d got=%b exp=0000", k, is_trigger); end
        end
    endtask

    // Asynchronous reset mid-WAIT clears everything immediately.
    task automatic test_reset_mid_wait();
        ch_mask = 4'b1111; delay_frames = 8'd3; hold_frames = 4'd0;
        wait_fc(4'd2);
        trigger_in = 1'b1;
        @(negedge clk); trigger_in = 1'b0;
        @(negedge clk); trigger_in = 1'b1;
        @(negedge clk); trigger_in = 1'b0;
        checks++; if (missed_count !== 8'd1) begin errors++; $display("FAIL rstw pre missed got=%0d exp=1", missed_count); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstw pre busy got=%b exp=1", busy); end
        #2 reset = 1'b1;
        #1;
        checks++; if (is_trigger !== 4'b0000) begin errors++; $display("FAIL rstw is_trigger got=%b exp=0000", is_trigger); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstw busy got=%b exp=0", busy); end
        checks++; if (frame_counter !== 4'd0) begin errors++; $display("FAIL rstw frame_counter got=%0d exp=0", frame_counter); end
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL rstw frame_tick got=%b exp=0", frame_tick); end
        checks++; if (missed_count !== 8'd0) begin errors++; $display("FAIL rstw missed got=%0d exp=0", missed_count); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++; if (frame_counter !== 4'd1) begin errors++; $display("FAIL rstw restart got=%0d exp=1", frame_counter); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstw restart busy got=%b exp=0", busy); end
    endtask

    initial begin
        reset        = 1'b1;
        enable       = 1'b1;
        trigger_in   = 1'b0;
        ch_mask      = 4'b0000;
        delay_frames = 8'd0;
        hold_frames  = 4'd0;
        retrig_mode  = 1'b0;
        clear_missed = 1'b0;
        test_reset();
        test_basic();
        test_delay();
        test_tick_align();
        test_missed_retrig();
        test_saturate();
        test_enable_abort();
        test_zero_mask();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
